// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART transmitter.
// Optional parity is enabled with the UART_TX_PARITY_EN macro; without it the
// PARITY state does not exist and frames go straight from data to stop.
package uart_pkg;

    localparam logic IDLE_LEVEL = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_t;

    // Ceiling log2 usable in constant expressions; clog2(1) = 0.
    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r++;
            x = x >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous word FIFO feeding the transmitter. Pointers carry one extra
// wrap bit so full and empty are distinguished without a separate counter.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [DATA_W-1:0]            wdata,
    input  logic                         pop,
    output logic [DATA_W-1:0]            rdata,
    output logic [clog2(FIFO_DEPTH):0]   level,
    output logic                         full,
    output logic                         empty
);

    localparam int AW = clog2(FIFO_DEPTH);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign level = wr_ptr - rd_ptr;
    assign rdata = mem[rd_ptr[AW-1:0]];

    // Storage array; contents need no reset since pointers gate every read.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    // Read/write pointers; a reset flushes all queued words.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: word FIFO with valid/ready input, internal
// baud divider, DATA_W data bits LSB first, STOP_BITS stop bits.
// Define UART_TX_PARITY_EN to insert a parity bit (even, or odd with
// PARITY_ODD=1) between the data and stop bits.
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4,
    parameter int PARITY_ODD   = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         din_vld,
    input  logic [DATA_W-1:0]            din_byte,
    output logic                         din_rdy,
    output logic                         ser_out,
    output logic                         tx_busy,
    output logic                         uart_ready,
    output logic [clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int BIT_W  = clog2(DATA_W + 1);
    localparam int BAUD_W = clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_W - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

    // PARITY_ODD is a single flag; larger values have no meaning.
    if (PARITY_ODD > 1) begin : g_parity_odd_out_of_range
    end

    state_t              state_q, state_d;
    logic [BAUD_W-1:0]   baud_q, baud_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [DATA_W-1:0]   shreg_q, shreg_d;
    logic                ser_d;
    logic                baud_end;
    logic                pop;
    logic [DATA_W-1:0]   fifo_rdata;
    logic                fifo_full;
    logic                fifo_empty;
`ifdef UART_TX_PARITY_EN
    logic [DATA_W-1:0]   word_q, word_d;
`endif

    uart_tx_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (din_vld),
        .wdata (din_byte),
        .pop   (pop),
        .rdata (fifo_rdata),
        .level (fifo_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign din_rdy    = !fifo_full;
    assign tx_busy    = (state_q != IDLE);
    assign uart_ready = fifo_empty && (state_q == IDLE);
    assign baud_end   = (baud_q == BAUD_LAST);

    // State, counters and shift register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
        end
    end

`ifdef UART_TX_PARITY_EN
    // Copy of the popped word; parity must not see the shifting register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) word_q <= '0;
        else        word_q <= word_d;
    end
`endif

    // Registered line driver; reset forces the line idle immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ser_out <= IDLE_LEVEL;
        else        ser_out <= ser_d;
    end

    // Next-state logic: frame sequencing, baud/bit counting, FIFO pops.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
        word_d  = word_q;
`endif
        if (state_q != IDLE) baud_d = baud_end ? '0 : baud_q + 1'b1;

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shreg_d = fifo_rdata;
`ifdef UART_TX_PARITY_EN
                    word_d  = fifo_rdata;
`endif
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                if (baud_end) state_d = DATA;
            end
            DATA: begin
                if (baud_end) begin
                    shreg_d = shreg_q >> 1;
                    if (bit_q == DATA_LAST) begin
                        bit_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (baud_end) state_d = STOP;
            end
`endif
            STOP: begin
                if (baud_end) begin
                    if (bit_q == STOP_LAST) begin
                        bit_d = '0;
                        if (!fifo_empty) begin
                            // Back-to-back: next start bit follows the last stop bit directly.
                            pop     = 1'b1;
                            shreg_d = fifo_rdata;
`ifdef UART_TX_PARITY_EN
                            word_d  = fifo_rdata;
`endif
                            state_d = START;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Line level for the current state, registered one cycle later.
    always_comb begin
        ser_d = IDLE_LEVEL;
        case (state_q)
            START:  ser_d = 1'b0;
            DATA:   ser_d = shreg_q[0];
`ifdef UART_TX_PARITY_EN
            PARITY: ser_d = (^word_q) ^ 1'(PARITY_ODD);
`endif
            default: ser_d = IDLE_LEVEL;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: DATA_W=8, CLKS_PER_BIT=4, FIFO_DEPTH=4.
// Main instance uses one stop bit; a second instance uses two stop bits.
// Line values are logged once per cycle and compared against expected frames.
module tb_uart_tx_param;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int FL1 = (1 + 8 + PB + 1) * CPB;
    localparam int FL2 = (1 + 8 + PB + 2) * CPB;
    localparam int RECN = 4096;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       din_vld = 1'b0;
    logic [7:0] din_byte = '0;
    logic       din_rdy, ser_out, tx_busy, uart_ready;
    logic [2:0] fifo_level;
    logic       d2_vld = 1'b0;
    logic [7:0] d2_byte = '0;
    logic       d2_rdy, d2_ser, d2_busy, d2_ready;
    logic [2:0] d2_level;

    int n_tests = 0;
    int n_fail  = 0;
    int ecnt    = 0;
    logic rec1 [RECN];
    logic rec2 [RECN];

    uart_tx_param #(.DATA_W(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1), .FIFO_DEPTH(4), .PARITY_ODD(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .din_vld(din_vld), .din_byte(din_byte), .din_rdy(din_rdy),
        .ser_out(ser_out), .tx_busy(tx_busy), .uart_ready(uart_ready), .fifo_level(fifo_level));

    uart_tx_param #(.DATA_W(8), .CLKS_PER_BIT(CPB), .STOP_BITS(2), .FIFO_DEPTH(4), .PARITY_ODD(0)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .din_vld(d2_vld), .din_byte(d2_byte), .din_rdy(d2_rdy),
        .ser_out(d2_ser), .tx_busy(d2_busy), .uart_ready(d2_ready), .fifo_level(d2_level));

    always #5 clk = ~clk;

    // ecnt = index of the most recent rising edge; rec[e] = line after edge e.
    always @(posedge clk) ecnt <= ecnt + 1;
    always @(negedge clk) begin
        if (ecnt < RECN) begin
            rec1[ecnt] = ser_out;
            rec2[ecnt] = d2_ser;
        end
    end

    typedef struct {
        logic [7:0] w;
        logic [9:0] frame;  // bit 0 sent first: start, data LSB..MSB, stop
        logic       par;    // even parity bit
    } vec_t;

    vec_t tbl [6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [7:0] w);
        vec_t v;
        v.w = w;
        v.frame = {1'b1, w, 1'b0};
        v.par = ^w;
        return v;
    endfunction

    // Compare one frame starting at rec index 'start': bit values at mid-bit,
    // plus every cycle of every bit holding the same level.
    task automatic check_frame(input string nm, input int start, input vec_t v,
                               input int stops, input bit second);
        logic [15:0] eb, ab;
        int nb, len, guard, hold_err;
        logic s;
        eb = 16'hFFFF;
        eb[8:0] = v.frame[8:0];
        eb[9] = (PB == 1) ? v.par : v.frame[9];
        nb = 10 + PB + stops - 1;
        len = nb * CPB;
        guard = 0;
        while (ecnt < start + len && guard < 2000) begin
            tick();
            guard++;
        end
        if (guard >= 2000) begin
            chk({nm, " timeout"}, 1, 0);
        end else begin
            ab = 16'hFFFF;
            hold_err = 0;
            for (int b = 0; b < nb; b++) begin
                ab[b] = second ? rec2[start + b*CPB + CPB/2] : rec1[start + b*CPB + CPB/2];
                for (int c = 0; c < CPB; c++) begin
                    s = second ? rec2[start + b*CPB + c] : rec1[start + b*CPB + c];
                    if (s !== eb[b]) hold_err++;
                end
            end
            chk({nm, " bits"}, 32'(ab), 32'(eb));
            chk({nm, " hold"}, 32'(hold_err), 0);
        end
    endtask

    // Push with handshake; returns the edge index at which the word was taken.
    task automatic push_hs(input logic [7:0] w, output int at);
        logic ok;
        int guard;
        din_vld = 1'b1;
        din_byte = w;
        guard = 0;
        do begin
            ok = din_rdy;
            tick();
            guard++;
        end while (!ok && guard < 500);
        at = ecnt;
        if (!ok) chk("push timeout", 1, 0);
        din_vld = 1'b0;
        din_byte = 8'h3C;
    endtask

    initial begin
        int n, start, e, zeros;
        vec_t v;

        tbl[0] = '{8'hA5, 10'b1_10100101_0, 1'b0};
        tbl[1] = '{8'h07, 10'b1_00000111_0, 1'b1};
        tbl[2] = '{8'h00, 10'b1_00000000_0, 1'b0};
        tbl[3] = '{8'hFF, 10'b1_11111111_0, 1'b0};
        tbl[4] = '{8'h01, 10'b1_00000001_0, 1'b1};
        tbl[5] = '{8'h80, 10'b1_10000000_0, 1'b1};

        // Reset state
        repeat (3) tick();
        chk("reset ser_out", 32'(ser_out), 1);
        chk("reset din_rdy", 32'(din_rdy), 1);
        chk("reset tx_busy", 32'(tx_busy), 0);
        chk("reset uart_ready", 32'(uart_ready), 1);
        chk("reset fifo_level", 32'(fifo_level), 0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Single frames from the table, with latency checks
        for (int i = 0; i < 6; i++) begin
            din_vld = 1'b1;
            din_byte = tbl[i].w;
            tick();
            n = ecnt;
            din_vld = 1'b0;
            din_byte = 8'hC3;
            chk($sformatf("v%0d level after push", i), 32'(fifo_level), 1);
            chk($sformatf("v%0d ready after push", i), 32'(uart_ready), 0);
            chk($sformatf("v%0d busy before pop", i), 32'(tx_busy), 0);
            tick();
            chk($sformatf("v%0d line idle at pop", i), 32'(ser_out), 1);
            chk($sformatf("v%0d busy after pop", i), 32'(tx_busy), 1);
            chk($sformatf("v%0d level after pop", i), 32'(fifo_level), 0);
            check_frame($sformatf("v%0d frame", i), n + 2, tbl[i], 1, 1'b0);
            chk($sformatf("v%0d ready after frame", i), 32'(uart_ready), 1);
            chk($sformatf("v%0d busy after frame", i), 32'(tx_busy), 0);
            repeat (3) tick();
        end

        // Back-to-back frames, no idle cycle between stop and next start
        din_vld = 1'b1;
        din_byte = 8'h01; tick(); n = ecnt;
        din_byte = 8'h02; tick();
        din_byte = 8'h03; tick();
        din_vld = 1'b0;
        for (int k = 0; k < 3; k++)
            check_frame($sformatf("b2b%0d", k), n + 2 + k*FL1, mk(8'(k + 1)), 1, 1'b0);
        chk("b2b ready", 32'(uart_ready), 1);
        repeat (3) tick();

        // FIFO full back-pressure: 5 pushes while busy, sixth word waits
        push_hs(8'h10, n);
        push_hs(8'h21, e);
        push_hs(8'h32, e);
        push_hs(8'h43, e);
        push_hs(8'h54, e);
        chk("full din_rdy", 32'(din_rdy), 0);
        chk("full fifo_level", 32'(fifo_level), 4);
        din_vld = 1'b1;
        din_byte = 8'h77;
        tick();
        chk("full level after refused push", 32'(fifo_level), 4);
        push_hs(8'h65, e);
        chk("late push edge", 32'(e), 32'(n + 2 + FL1));
        for (int k = 0; k < 6; k++)
            check_frame($sformatf("full%0d", k), n + 2 + k*FL1, mk(8'(8'h10 + k*8'h11)), 1, 1'b0);
        chk("full drained", 32'(uart_ready), 1);
        repeat (3) tick();

        // Two stop bits
        d2_vld = 1'b1;
        d2_byte = 8'hFF; tick(); n = ecnt;
        d2_byte = 8'h00; tick();
        d2_vld = 1'b0;
        check_frame("stop2 first", n + 2, mk(8'hFF), 2, 1'b1);
        check_frame("stop2 second", n + 2 + FL2, mk(8'h00), 2, 1'b1);
        chk("stop2 ready", 32'(d2_ready), 1);
        repeat (3) tick();

        // Reset during DATA of the second of three queued frames
        din_vld = 1'b1;
        din_byte = 8'hAA; tick(); n = ecnt;
        din_byte = 8'h00; tick();
        din_byte = 8'h55; tick();
        din_vld = 1'b0;
        start = n + 2 + FL1;
        while (ecnt < start + CPB + 6) tick();
        chk("mid-frame line low", 32'(ser_out), 0);
        chk("mid-frame level", 32'(fifo_level), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset ser_out", 32'(ser_out), 1);
        chk("async reset level", 32'(fifo_level), 0);
        chk("async reset busy", 32'(tx_busy), 0);
        chk("async reset din_rdy", 32'(din_rdy), 1);
        repeat (2) tick();
        rst_n = 1'b1;
        e = ecnt;
        repeat (2*FL1 + 2) tick();
        zeros = 0;
        for (int i = e; i < e + 2*FL1; i++)
            if (rec1[i] !== 1'b1) zeros++;
        chk("no frames after reset", 32'(zeros), 0);
        chk("ready after reset", 32'(uart_ready), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
